cordic_vector_sequencer: RTL and testbench

//  Iterative vectoring-mode CORDIC controller. It converts one complex sample (x_re, x_im) into a phase and an

---
 rtl/cordic_vector_sequencer_if.sv | 32 +++
 rtl/cordic_vector_sequencer.sv | 157 +++++++++++++++
 tb/tb_cordic_vector_sequencer.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/cordic_vector_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module   : cordic_vector_sequencer_if
//  Brief    : Sample-in / phase+magnitude-out handshake bundle for the CORDIC
//             vectoring sequencer.
//  Revision : 1.0 - initial release
// ============================================================================
interface cordic_vector_sequencer_if #(
    parameter int DW = 16,
    parameter int PW = 18
);
    logic                 in_valid;
    logic                 in_ready;
    logic signed [DW-1:0] x_re;
    logic signed [DW-1:0] x_im;
    logic                 out_valid;
    logic                 out_ready;
    logic [PW-1:0]        phase;
    logic [DW+1:0]        mag;
    logic                 busy;

    modport slave (
        input  in_valid, x_re, x_im, out_ready,
        output in_ready, out_valid, phase, mag, busy
    );

    modport master (
        output in_valid, x_re, x_im, out_ready,
        input  in_ready, out_valid, phase, mag, busy
    );
endinterface
`default_nettype wire

// File: rtl/cordic_vector_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : cordic_vector_sequencer
//  Brief    : Iterative vectoring-mode CORDIC: one complex sample in, phase and
//             uncompensated magnitude out after ITERS shift-add cycles.
//  Revision : 1.0 - initial release
// ============================================================================
module cordic_vector_sequencer #(
    parameter int DW    = 16,
    parameter int PW    = 18,
    parameter int ITERS = 14
) (
    input  logic                     clk,
    input  logic                     reset,
    cordic_vector_sequencer_if.slave bus
);
    localparam int           XW       = DW + 2;
    localparam int           CW       = $clog2(ITERS + 1);
    localparam logic [127:0] c_PI_F60 = 128'h3243F6A8885A308D;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ROT  = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    state_t               r_state, w_state_nxt;
    logic signed [XW-1:0] r_x, r_y, w_x_nxt, w_y_nxt, w_xs, w_ys;
    logic signed [XW-1:0] w_re_ext, w_im_ext;
    logic [PW-1:0]        r_z, w_z_nxt, r_phase, w_atan_i;
    logic [XW-1:0]        r_mag;
    logic [CW-1:0]        r_i;
    logic                 r_zero, w_accept, w_last;
    logic [PW-1:0]        w_atan [ITERS];

    // atan(2^-i)/pi scaled to half-circle = 2^(PW-1), evaluated at elaboration
    // with a 60-bit fixed-point Taylor series (exact powers of two per term).
    function automatic logic [PW-1:0] f_atan(input int i);
        logic [127:0]  acc;
        logic [127:0]  term;
        int            sh;
        logic [PW-1:0] res;
        acc = '0;
        res = '0;
        if (i == 0) begin
            res[PW-3] = 1'b1;
        end else begin
            for (int k = 0; k < 64; k++) begin
                sh = 60 - i * (2 * k + 1);
                if (sh >= 0) begin
                    term = (128'd1 << sh) / 128'(2 * k + 1);
                    if (k % 2 == 0) acc = acc + term;
                    else            acc = acc - term;
                end
            end
            acc = ((acc << (PW - 1)) + (c_PI_F60 >> 1)) / c_PI_F60;
            res = acc[PW-1:0];
        end
        return res;
    endfunction

    for (genvar g = 0; g < ITERS; g++) begin : g_atan
        localparam logic [PW-1:0] c_ATAN = f_atan(g);
        assign w_atan[g] = c_ATAN;
    end

    assign w_re_ext = {{2{bus.x_re[DW-1]}}, bus.x_re};
    assign w_im_ext = {{2{bus.x_im[DW-1]}}, bus.x_im};
    assign w_xs     = r_x >>> r_i;
    assign w_ys     = r_y >>> r_i;
    assign w_atan_i = w_atan[r_i];

    always_comb begin
        w_x_nxt = r_x;
        w_y_nxt = r_y;
        w_z_nxt = r_z;
        if (!r_y[XW-1]) begin
            w_x_nxt = r_x + w_ys;
            w_y_nxt = r_y - w_xs;
            w_z_nxt = r_z + w_atan_i;
        end else begin
            w_x_nxt = r_x - w_ys;
            w_y_nxt = r_y + w_xs;
            w_z_nxt = r_z - w_atan_i;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_last      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.in_valid) begin
                    w_accept    = 1'b1;
                    w_state_nxt = S_ROT;
                end
            end
            S_ROT: begin
                if (r_i == CW'(ITERS - 1)) begin
                    w_last      = 1'b1;
                    w_state_nxt = S_HOLD;
                end
            end
            S_HOLD: begin
                if (bus.out_ready) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_x     <= '0;
            r_y     <= '0;
            r_z     <= '0;
            r_i     <= '0;
            r_zero  <= 1'b0;
            r_phase <= '0;
            r_mag   <= '0;
        end else if (w_accept) begin
            // Left half-plane is folded by pi so the micro-rotations converge.
            if (bus.x_re[DW-1]) begin
                r_x <= -w_re_ext;
                r_y <= -w_im_ext;
                r_z <= {1'b1, {(PW-1){1'b0}}};
            end else begin
                r_x <= w_re_ext;
                r_y <= w_im_ext;
                r_z <= '0;
            end
            r_zero <= (bus.x_re == '0) && (bus.x_im == '0);
            r_i    <= '0;
        end else if (r_state == S_ROT) begin
            r_x <= w_x_nxt;
            r_y <= w_y_nxt;
            r_z <= w_z_nxt;
            r_i <= r_i + CW'(1);
            if (w_last) begin
                r_phase <= r_zero ? '0 : w_z_nxt;
                r_mag   <= r_zero ? '0 : w_x_nxt;
            end
        end
    end

    assign bus.in_ready  = (r_state == S_IDLE);
    assign bus.busy      = (r_state != S_IDLE);
    assign bus.out_valid = (r_state == S_HOLD);
    assign bus.phase     = r_phase;
    assign bus.mag       = r_mag;
endmodule
`default_nettype wire

// File: tb/tb_cordic_vector_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_cordic_vector_sequencer
//  Brief    : Directed and randomized checks of the CORDIC vectoring sequencer
//             against an arithmetic reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_cordic_vector_sequencer;
    localparam int DW       = 16;
    localparam int PW       = 18;
    localparam int ITERS    = 14;
    localparam int N_STREAM = 1000;

    logic   clk;
    logic   reset;
    int     n_checks;
    int     n_errors;
    longint atan_tab [ITERS];
    longint q_ph [$];
    longint q_mg [$];

    cordic_vector_sequencer_if #(.DW(DW), .PW(PW)) bus ();

    cordic_vector_sequencer #(.DW(DW), .PW(PW), .ITERS(ITERS)) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input longint obs, input longint exp);
        n_checks++;
        if (obs != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Vectoring CORDIC written straight from the rotation rules.
    task automatic model(input int re, input int im, output longint ph, output longint mg);
        longint x, y, z, xn, yn;
        if (re < 0) begin
            x = -longint'(re); y = -longint'(im); z = longint'(1) << (PW - 1);
        end else begin
            x = re; y = im; z = 0;
        end
        for (int i = 0; i < ITERS; i++) begin
            if (y >= 0) begin
                xn = x + (y >>> i); yn = y - (x >>> i); z = z + atan_tab[i];
            end else begin
                xn = x - (y >>> i); yn = y + (x >>> i); z = z - atan_tab[i];
            end
            x = xn; y = yn;
        end
        if (re == 0 && im == 0) begin
            ph = 0; mg = 0;
        end else begin
            ph = z & ((longint'(1) << PW) - 1);
            mg = x & ((longint'(1) << (DW + 2)) - 1);
        end
    endtask

    task automatic wait_result(input string tag);
        int n;
        n = 0;
        do begin
            @(posedge clk); #1; n++;
        end while (!bus.out_valid && n < 40);
        check(tag, n, ITERS);
    endtask

    task automatic run_one(input int re, input int im);
        longint eph, emg;
        model(re, im, eph, emg);
        bus.x_re = DW'(re); bus.x_im = DW'(im);
        bus.in_valid = 1'b1; bus.out_ready = 1'b0;
        check("dir_in_ready", bus.in_ready, 1);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        check("dir_busy", bus.busy, 1);
        wait_result("dir_latency");
        check("dir_phase", bus.phase, eph);
        check("dir_mag", bus.mag, emg);
        repeat (2) begin @(posedge clk); #1; end
        check("dir_hold_valid", bus.out_valid, 1);
        check("dir_hold_phase", bus.phase, eph);
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        check("dir_valid_clear", bus.out_valid, 0);
        check("dir_phase_kept", bus.phase, eph);
    endtask

    task automatic test_backpressure();
        longint pa, ma, pb, mb;
        model(12000, -7000, pa, ma);
        model(-5000, 20000, pb, mb);
        bus.x_re = 16'sd12000; bus.x_im = -16'sd7000;
        bus.in_valid = 1'b1; bus.out_ready = 1'b0;
        check("bp_idle", bus.in_ready, 1);
        @(posedge clk); #1;
        bus.x_re = -16'sd5000; bus.x_im = 16'sd20000;
        wait_result("bp_latency_a");
        for (int c = 0; c < 5; c++) begin
            check("bp_in_ready", bus.in_ready, 0);
            check("bp_valid", bus.out_valid, 1);
            check("bp_phase", bus.phase, pa);
            check("bp_mag", bus.mag, ma);
            @(posedge clk); #1;
        end
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        check("bp_released", bus.out_valid, 0);
        check("bp_idle_gap", bus.in_ready, 1);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        check("bp_second_accept", bus.busy, 1);
        wait_result("bp_latency_b");
        check("bp_phase_b", bus.phase, pb);
        check("bp_mag_b", bus.mag, mb);
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset_abort();
        int seen;
        bus.x_re = 16'sd16384; bus.x_im = 16'sd0; bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #3 reset = 1'b1;
        #1;
        check("rst_busy", bus.busy, 0);
        check("rst_in_ready", bus.in_ready, 1);
        check("rst_valid", bus.out_valid, 0);
        check("rst_phase", bus.phase, 0);
        check("rst_mag", bus.mag, 0);
        @(posedge clk); #1;
        reset = 1'b0;
        seen = 0;
        repeat (20) begin
            @(posedge clk); #1;
            if (bus.out_valid) seen++;
        end
        check("rst_no_valid", seen, 0);
        run_one(16384, 0);
    endtask

    task automatic stream_driver();
        int re, im, g;
        bit acc;
        longint ph, mg;
        for (int s = 0; s < N_STREAM; s++) begin
            repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
            if ($urandom_range(0, 15) == 0) begin
                case ($urandom_range(0, 3))
                    0: begin re = -32768; im = -32768; end
                    1: begin re = 0;      im = 0;      end
                    2: begin re = 32767;  im = -32768; end
                    default: begin re = -32768; im = 32767; end
                endcase
            end else begin
                re = int'($urandom_range(0, 65535)) - 32768;
                im = int'($urandom_range(0, 65535)) - 32768;
            end
            bus.x_re = DW'(re); bus.x_im = DW'(im); bus.in_valid = 1'b1;
            g = 0;
            do begin
                acc = bus.in_ready;
                @(posedge clk); #1; g++;
            end while (!acc && g < 200);
            bus.in_valid = 1'b0;
            if (!acc) begin
                check("stream_accept", acc, 1);
                break;
            end
            model(re, im, ph, mg);
            q_ph.push_back(ph);
            q_mg.push_back(mg);
        end
    endtask

    task automatic stream_monitor();
        int rx, cyc;
        rx = 0; cyc = 0;
        while (rx < N_STREAM && cyc < 60000) begin
            bus.out_ready = ($urandom_range(0, 9) < 6);
            if (bus.out_valid && bus.out_ready) begin
                check("stream_expected", q_ph.size() > 0, 1);
                if (q_ph.size() > 0) begin
                    check("stream_phase", bus.phase, q_ph.pop_front());
                    check("stream_mag", bus.mag, q_mg.pop_front());
                end
                rx++;
            end
            @(posedge clk); #1; cyc++;
        end
        bus.out_ready = 1'b0;
        check("stream_count", rx, N_STREAM);
        check("stream_leftover", q_ph.size(), 0);
    endtask

    int dir_re [7] = '{16384, 0, 10000, -32768, -16384, -16384, 0};
    int dir_im [7] = '{0, 16384, 10000, -32768, 1, -1, 0};

    initial begin
        n_checks = 0;
        n_errors = 0;
        for (int i = 0; i < ITERS; i++)
            atan_tab[i] = longint'($rtoi($atan(2.0 ** (-i)) * (2.0 ** (PW - 1)) / 3.141592653589793 + 0.5));
        reset = 1'b1;
        bus.in_valid = 1'b0; bus.x_re = '0; bus.x_im = '0; bus.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_in_ready", bus.in_ready, 1);
        check("reset_busy", bus.busy, 0);
        check("reset_valid", bus.out_valid, 0);
        check("reset_phase", bus.phase, 0);
        check("reset_mag", bus.mag, 0);
        reset = 1'b0;
        @(posedge clk); #1;

        for (int d = 0; d < 7; d++) run_one(dir_re[d], dir_im[d]);
        test_backpressure();
        test_reset_abort();

        fork
            stream_driver();
            stream_monitor();
        join

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
`default_nettype wire
